// File: rtl/redmule_stream_addrgen.sv
// Streamer address generator: takes a 3-D descriptor on start and walks it over a valid/ready address stream.
// Optional sticky misalignment flag enabled by defining REDMULE_ADDRGEN_ALIGN_CHECK_EN.
module redmule_stream_addrgen #(
  parameter int unsigned AW    = 32,
  parameter int unsigned LW    = 32,
  parameter int unsigned ALIGN = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          req_start_i,
  input  logic [AW-1:0] base_addr_i,
  input  logic [LW-1:0] tot_len_i,
  input  logic [LW-1:0] d0_len_i,
  input  logic [AW-1:0] d0_stride_i,
  input  logic [LW-1:0] d1_len_i,
  input  logic [AW-1:0] d1_stride_i,
  input  logic [AW-1:0] d2_stride_i,
  input  logic [1:0]    dim_enable_1h_i,
  output logic          ready_start_o,
  output logic          done_o,
  output logic [AW-1:0] addr_o,
  output logic          addr_valid_o,
  input  logic          addr_ready_i
`ifdef REDMULE_ADDRGEN_ALIGN_CHECK_EN
  ,
  output logic          misalign_o
`endif
);

  localparam logic [LW-1:0] LW_ZERO = {LW{1'b0}};
  localparam logic [LW-1:0] LW_ONE  = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] AW_ZERO = {AW{1'b0}};

  if ((ALIGN == 32'd0) || ((ALIGN & (ALIGN - 32'd1)) != 32'd0)) begin : g_align_invalid
    $error("ALIGN must be a power of two");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e        r_state;
  state_e        w_state_next;

  logic [LW-1:0] r_tot_len;
  logic [LW-1:0] r_d0_last;
  logic [LW-1:0] r_d1_last;
  logic [AW-1:0] r_d0_stride;
  logic [AW-1:0] r_d1_stride;
  logic [AW-1:0] r_d2_stride;
  logic [1:0]    r_dim;
  logic [LW-1:0] r_cnt;
  logic [LW-1:0] r_d0_cnt;
  logic [LW-1:0] r_d1_cnt;
  logic [AW-1:0] r_d1_base;
  logic [AW-1:0] r_d2_base;
  logic [AW-1:0] r_addr;
  logic          r_ready_start;
  logic          r_done;
  logic          r_addr_valid;

  logic          w_start;
  logic          w_hs;
  logic          w_last;
  logic          w_d0_wrap;
  logic          w_d1_wrap;
  logic [LW-1:0] w_d0_cnt_next;
  logic [LW-1:0] w_d1_cnt_next;
  logic [AW-1:0] w_d1_base_next;
  logic [AW-1:0] w_d2_base_next;
  logic [AW-1:0] w_addr_next;

  assign w_start   = (r_state == ST_IDLE) && req_start_i;
  assign w_hs      = r_addr_valid && addr_ready_i;
  assign w_last    = (r_cnt == (r_tot_len - LW_ONE));
  assign w_d0_wrap = r_dim[0] && (r_d0_cnt == r_d0_last);
  assign w_d1_wrap = w_d0_wrap && r_dim[1] && (r_d1_cnt == r_d1_last);

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_start_i) begin
          w_state_next = (tot_len_i == LW_ZERO) ? ST_DONE : ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_hs && w_last) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Address walk: inner step, d0 wrap onto next d1 row, or d1 wrap onto next d2 plane
  always_comb begin
    w_d0_cnt_next  = r_d0_cnt;
    w_d1_cnt_next  = r_d1_cnt;
    w_d1_base_next = r_d1_base;
    w_d2_base_next = r_d2_base;
    w_addr_next    = r_addr;
    if (!w_d0_wrap) begin
      w_d0_cnt_next = r_d0_cnt + LW_ONE;
      w_addr_next   = r_addr + r_d0_stride;
    end else if (!w_d1_wrap) begin
      w_d0_cnt_next  = LW_ZERO;
      w_d1_cnt_next  = r_d1_cnt + LW_ONE;
      w_d1_base_next = r_d1_base + r_d1_stride;
      w_addr_next    = r_d1_base + r_d1_stride;
    end else begin
      w_d0_cnt_next  = LW_ZERO;
      w_d1_cnt_next  = LW_ZERO;
      w_d2_base_next = r_d2_base + r_d2_stride;
      w_d1_base_next = r_d2_base + r_d2_stride;
      w_addr_next    = r_d2_base + r_d2_stride;
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else if (clear_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Handshake outputs registered from the next state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ready_start <= 1'b1;
      r_done        <= 1'b0;
      r_addr_valid  <= 1'b0;
    end else if (clear_i) begin
      r_ready_start <= 1'b1;
      r_done        <= 1'b0;
      r_addr_valid  <= 1'b0;
    end else begin
      r_ready_start <= (w_state_next == ST_IDLE);
      r_done        <= (w_state_next == ST_DONE);
      r_addr_valid  <= (w_state_next == ST_RUN);
    end
  end

  // Descriptor capture and counter/address datapath
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tot_len   <= LW_ZERO;
      r_d0_last   <= LW_ZERO;
      r_d1_last   <= LW_ZERO;
      r_d0_stride <= AW_ZERO;
      r_d1_stride <= AW_ZERO;
      r_d2_stride <= AW_ZERO;
      r_dim       <= 2'b00;
      r_cnt       <= LW_ZERO;
      r_d0_cnt    <= LW_ZERO;
      r_d1_cnt    <= LW_ZERO;
      r_d1_base   <= AW_ZERO;
      r_d2_base   <= AW_ZERO;
      r_addr      <= AW_ZERO;
    end else if (clear_i) begin
      r_tot_len   <= LW_ZERO;
      r_d0_last   <= LW_ZERO;
      r_d1_last   <= LW_ZERO;
      r_d0_stride <= AW_ZERO;
      r_d1_stride <= AW_ZERO;
      r_d2_stride <= AW_ZERO;
      r_dim       <= 2'b00;
      r_cnt       <= LW_ZERO;
      r_d0_cnt    <= LW_ZERO;
      r_d1_cnt    <= LW_ZERO;
      r_d1_base   <= AW_ZERO;
      r_d2_base   <= AW_ZERO;
      r_addr      <= AW_ZERO;
    end else if (w_start) begin
      // A zero length field behaves as length one, so its last index is 0
      r_tot_len   <= tot_len_i;
      r_d0_last   <= (d0_len_i == LW_ZERO) ? LW_ZERO : (d0_len_i - LW_ONE);
      r_d1_last   <= (d1_len_i == LW_ZERO) ? LW_ZERO : (d1_len_i - LW_ONE);
      r_d0_stride <= d0_stride_i;
      r_d1_stride <= d1_stride_i;
      r_d2_stride <= d2_stride_i;
      r_dim       <= dim_enable_1h_i;
      r_cnt       <= LW_ZERO;
      r_d0_cnt    <= LW_ZERO;
      r_d1_cnt    <= LW_ZERO;
      r_d1_base   <= base_addr_i;
      r_d2_base   <= base_addr_i;
      if (tot_len_i != LW_ZERO) begin
        r_addr <= base_addr_i;
      end
    end else if (w_hs) begin
      r_cnt     <= r_cnt + LW_ONE;
      r_d0_cnt  <= w_d0_cnt_next;
      r_d1_cnt  <= w_d1_cnt_next;
      r_d1_base <= w_d1_base_next;
      r_d2_base <= w_d2_base_next;
      r_addr    <= w_addr_next;
    end
  end

  assign ready_start_o = r_ready_start;
  assign done_o        = r_done;
  assign addr_o        = r_addr;
  assign addr_valid_o  = r_addr_valid;

`ifdef REDMULE_ADDRGEN_ALIGN_CHECK_EN
  localparam logic [AW-1:0] ALIGN_MASK = AW'(ALIGN - 32'd1);

  logic r_misalign;

  // Sticky flag for any accepted address off the ALIGN grid
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_misalign <= 1'b0;
    end else if (clear_i) begin
      r_misalign <= 1'b0;
    end else if (w_start) begin
      r_misalign <= 1'b0;
    end else if (w_hs && ((r_addr & ALIGN_MASK) != AW_ZERO)) begin
      r_misalign <= 1'b1;
    end
  end

  assign misalign_o = r_misalign;
`endif

endmodule

// File: tb/tb_redmule_stream_addrgen.sv
// Directed self-checking bench for redmule_stream_addrgen: 2-D/3-D walks, backpressure, zero length, clear, wrap.
module tb_redmule_stream_addrgen;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clear_i;
  logic        req_start_i;
  logic [31:0] base_addr_i;
  logic [31:0] tot_len_i;
  logic [31:0] d0_len_i;
  logic [31:0] d0_stride_i;
  logic [31:0] d1_len_i;
  logic [31:0] d1_stride_i;
  logic [31:0] d2_stride_i;
  logic [1:0]  dim_enable_1h_i;
  logic        ready_start_o;
  logic        done_o;
  logic [31:0] addr_o;
  logic        addr_valid_o;
  logic        addr_ready_i;
`ifdef REDMULE_ADDRGEN_ALIGN_CHECK_EN
  logic        misalign_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  redmule_stream_addrgen #(.AW(32), .LW(32), .ALIGN(4)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .clear_i         (clear_i),
    .req_start_i     (req_start_i),
    .base_addr_i     (base_addr_i),
    .tot_len_i       (tot_len_i),
    .d0_len_i        (d0_len_i),
    .d0_stride_i     (d0_stride_i),
    .d1_len_i        (d1_len_i),
    .d1_stride_i     (d1_stride_i),
    .d2_stride_i     (d2_stride_i),
    .dim_enable_1h_i (dim_enable_1h_i),
    .ready_start_o   (ready_start_o),
    .done_o          (done_o),
    .addr_o          (addr_o),
    .addr_valid_o    (addr_valid_o),
    .addr_ready_i    (addr_ready_i)
`ifdef REDMULE_ADDRGEN_ALIGN_CHECK_EN
    ,
    .misalign_o      (misalign_o)
`endif
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_desc(input logic [31:0] base, input logic [31:0] tot,
                          input logic [31:0] d0l, input logic [31:0] d0s,
                          input logic [31:0] d1l, input logic [31:0] d1s,
                          input logic [31:0] d2s, input logic [1:0] dim);
    base_addr_i = base; tot_len_i = tot; d0_len_i = d0l; d0_stride_i = d0s;
    d1_len_i = d1l; d1_stride_i = d1s; d2_stride_i = d2s; dim_enable_1h_i = dim;
  endtask

  // Called right after the accepting edge; walks exp_q, then checks the done pulse and return to idle
  task automatic run_stream(input bit bp);
    int idx = 0;
    int cyc = 0;
    int hs  = 0;
    bit rdy;
    while (idx < exp_q.size() && cyc < 400) begin
      rdy = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      addr_ready_i = rdy;
      check("valid_run", {31'd0, addr_valid_o}, 32'd1);
      check("addr", addr_o, exp_q[idx]);
      check("done_run", {31'd0, done_o}, 32'd0);
      check("rs_run", {31'd0, ready_start_o}, 32'd0);
      tick();
      cyc++;
      if (rdy) begin
        idx++;
        hs++;
      end
    end
    check("hs_count", 32'(hs), 32'(exp_q.size()));
    addr_ready_i = 1'b1;
    req_start_i  = 1'b0;
    check("done_pulse", {31'd0, done_o}, 32'd1);
    check("valid_done", {31'd0, addr_valid_o}, 32'd0);
    check("rs_done", {31'd0, ready_start_o}, 32'd0);
    tick();
    check("done_drop", {31'd0, done_o}, 32'd0);
    check("rs_idle", {31'd0, ready_start_o}, 32'd1);
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; req_start_i = 1'b0; addr_ready_i = 1'b1;
    set_desc(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    #12;
    check("rst_ready", {31'd0, ready_start_o}, 32'd1);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_valid", {31'd0, addr_valid_o}, 32'd0);
    check("rst_addr", addr_o, 32'h0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Basic 2-D; req_start held and descriptor scrambled during the run must be ignored
    set_desc(32'h1000, 32'd6, 32'd2, 32'h4, 32'd3, 32'h40, 32'h0, 2'b01);
    req_start_i = 1'b1;
    tick();
    set_desc(32'hDEAD0000, 32'd1, 32'd5, 32'h8, 32'd1, 32'h4, 32'h4, 2'b11);
    exp_q = '{32'h1000, 32'h1004, 32'h1040, 32'h1044, 32'h1080, 32'h1084};
    run_stream(1'b0);

    // 3-D wrap, started in the first idle cycle
    set_desc(32'h1000, 32'd6, 32'd2, 32'h4, 32'd2, 32'h40, 32'h200, 2'b11);
    req_start_i = 1'b1;
    tick();
    req_start_i = 1'b0;
    exp_q = '{32'h1000, 32'h1004, 32'h1040, 32'h1044, 32'h1200, 32'h1204};
    run_stream(1'b0);

    // Same 3-D walk under random backpressure
    req_start_i = 1'b1;
    tick();
    req_start_i = 1'b0;
    run_stream(1'b1);

    // d0_len=0 acts as 1: every step is a d0 wrap
    set_desc(32'h100, 32'd3, 32'd0, 32'h4, 32'd3, 32'h20, 32'h0, 2'b01);
    req_start_i = 1'b1;
    tick();
    req_start_i = 1'b0;
    exp_q = '{32'h100, 32'h120, 32'h140};
    run_stream(1'b0);

    // d1_len=0 acts as 1: every d0 wrap is a d1 wrap
    set_desc(32'h0, 32'd4, 32'd2, 32'h4, 32'd0, 32'h40, 32'h100, 2'b11);
    req_start_i = 1'b1;
    tick();
    req_start_i = 1'b0;
    exp_q = '{32'h0, 32'h4, 32'h100, 32'h104};
    run_stream(1'b0);

    // Zero length with req_start held: done next cycle, no valid, start ignored in DONE
    set_desc(32'h5000, 32'd0, 32'd1, 32'h4, 32'd1, 32'h0, 32'h0, 2'b00);
    req_start_i = 1'b1;
    tick();
    check("z_done", {31'd0, done_o}, 32'd1);
    check("z_valid", {31'd0, addr_valid_o}, 32'd0);
    check("z_rs", {31'd0, ready_start_o}, 32'd0);
    req_start_i = 1'b0;
    tick();
    check("z_done_drop", {31'd0, done_o}, 32'd0);
    check("z_rs_idle", {31'd0, ready_start_o}, 32'd1);
    check("z_valid_idle", {31'd0, addr_valid_o}, 32'd0);

    // Clear after three handshakes: back to idle, no done, then a fresh start
    set_desc(32'h2000, 32'd8, 32'd1, 32'h10, 32'd1, 32'h0, 32'h0, 2'b00);
    req_start_i = 1'b1;
    tick();
    req_start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("c_addr", addr_o, 32'h2000 + 32'(i) * 32'h10);
      tick();
    end
    check("c_addr3", addr_o, 32'h2030);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("c_rs", {31'd0, ready_start_o}, 32'd1);
    check("c_valid", {31'd0, addr_valid_o}, 32'd0);
    check("c_done", {31'd0, done_o}, 32'd0);
    check("c_addr0", addr_o, 32'h0);
    tick();
    check("c_nodone", {31'd0, done_o}, 32'd0);
    set_desc(32'h3000, 32'd2, 32'd1, 32'h4, 32'd1, 32'h0, 32'h0, 2'b00);
    req_start_i = 1'b1;
    tick();
    req_start_i = 1'b0;
    exp_q = '{32'h3000, 32'h3004};
    run_stream(1'b0);

    // Silent address wrap-around
    set_desc(32'hFFFF_FFFC, 32'd2, 32'd1, 32'h4, 32'd1, 32'h0, 32'h0, 2'b00);
    req_start_i = 1'b1;
    tick();
    req_start_i = 1'b0;
    exp_q = '{32'hFFFF_FFFC, 32'h0000_0000};
    run_stream(1'b0);

`ifdef REDMULE_ADDRGEN_ALIGN_CHECK_EN
    set_desc(32'h1002, 32'd2, 32'd1, 32'h4, 32'd1, 32'h0, 32'h0, 2'b00);
    req_start_i = 1'b1;
    addr_ready_i = 1'b0;
    tick();
    req_start_i = 1'b0;
    check("m_pre", {31'd0, misalign_o}, 32'd0);
    addr_ready_i = 1'b1;
    tick();
    check("m_set", {31'd0, misalign_o}, 32'd1);
    tick();
    check("m_done", {31'd0, done_o}, 32'd1);
    check("m_sticky", {31'd0, misalign_o}, 32'd1);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
    $fatal(1, "watchdog");
  end

endmodule
